// File: rtl/wb_pkg.sv
// wb_pkg: shared widths and the buffered writeback entry type
package wb_pkg;
  localparam int REG_ADDR_W = 5;
  localparam int DATA_W = 32;
  localparam int REG_COUNT = 32;
  typedef struct packed {
    logic [REG_ADDR_W-1:0] address;
    logic [DATA_W-1:0]     data;
  } wb_entry_t;
endpackage

// File: rtl/writeback_arbiter_if.sv
// writeback_arbiter_if: pipeline, LU, decode-query and register-file signals of the writeback stage
interface writeback_arbiter_if #(parameter int DEPTH = 4);
  import wb_pkg::*;
  logic                  pipe_write_enable;
  logic [REG_ADDR_W-1:0] pipe_write_address;
  logic [DATA_W-1:0]     pipe_write_data;
  logic                  pipe_stall;
  logic                  lu_issue;
  logic [REG_ADDR_W-1:0] lu_issue_address;
  logic                  lu_valid;
  logic [REG_ADDR_W-1:0] lu_address;
  logic [DATA_W-1:0]     lu_data;
  logic                  lu_ready;
  logic [REG_ADDR_W-1:0] query_address_a;
  logic [REG_ADDR_W-1:0] query_address_b;
  logic                  query_busy_a;
  logic                  query_busy_b;
  logic                  write_enable;
  logic [REG_ADDR_W-1:0] write_address;
  logic [DATA_W-1:0]     write_data;
  logic [$clog2(DEPTH):0] fifo_count;
  modport slave (
    input  pipe_write_enable, pipe_write_address, pipe_write_data,
    input  lu_issue, lu_issue_address, lu_valid, lu_address, lu_data,
    input  query_address_a, query_address_b,
    output pipe_stall, lu_ready, query_busy_a, query_busy_b,
    output write_enable, write_address, write_data, fifo_count
  );
  modport master (
    output pipe_write_enable, pipe_write_address, pipe_write_data,
    output lu_issue, lu_issue_address, lu_valid, lu_address, lu_data,
    output query_address_a, query_address_b,
    input  pipe_stall, lu_ready, query_busy_a, query_busy_b,
    input  write_enable, write_address, write_data, fifo_count
  );
endinterface

// File: rtl/writeback_fifo.sv
// writeback_fifo: DEPTH-entry circular buffer holding LU results until the write port is free
module writeback_fifo import wb_pkg::*; #(
  parameter int DEPTH = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  wb_entry_t              push_entry,
  output wb_entry_t              head,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);
  localparam int AW = $clog2(DEPTH);
  wb_entry_t mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  assign head  = mem[rd_ptr];
  assign full  = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(push);
      rd_ptr <= rd_ptr + AW'(pop);
      count  <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  always_ff @(posedge clock)
    if (push) mem[wr_ptr] <= push_entry;
endmodule

// File: rtl/writeback_arbiter.sv
// writeback_arbiter: merges pipeline and long-latency results onto the register-file write port
// Optional LU_BYPASS_EN: an LU result skips an empty FIFO when the pipe is idle
module writeback_arbiter import wb_pkg::*; #(
  parameter int DEPTH = 4,
  parameter int STARVE_LIMIT = 8
) (
  input logic               clock,
  input logic               reset,
  writeback_arbiter_if.slave bus
);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  wb_entry_t head, lu_entry;
  logic full, empty, push, pop, bypass, pipe_hit;
  logic [REG_COUNT-1:0] pending, clr_mask, set_mask;
  logic [SW-1:0] starve, starve_next;
  assign lu_entry = '{address: bus.lu_address, data: bus.lu_data};
  writeback_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock(clock), .reset(reset), .push(push), .pop(pop), .push_entry(lu_entry),
    .head(head), .count(bus.fifo_count), .full(full), .empty(empty)
  );
`ifdef LU_BYPASS_EN
  assign bypass = empty && !bus.pipe_write_enable && bus.lu_valid && bus.lu_address != '0;
`else
  assign bypass = 1'b0;
`endif
  assign bus.lu_ready = !full;
  // a presented pipe write always owns the port, even one to r0
  assign pop      = !bus.pipe_write_enable && !empty;
  assign push     = bus.lu_valid && !full && bus.lu_address != '0 && !bypass;
  assign pipe_hit = bus.pipe_write_enable && bus.pipe_write_address != '0;
  assign clr_mask = pop ? REG_COUNT'(1) << head.address : bypass ? REG_COUNT'(1) << bus.lu_address : '0;
  assign set_mask = (bus.lu_issue && bus.lu_issue_address != '0) ? REG_COUNT'(1) << bus.lu_issue_address : '0;
  assign bus.query_busy_a = pending[bus.query_address_a];
  assign bus.query_busy_b = pending[bus.query_address_b];
  assign starve_next = (pop || empty) ? '0 : starve == SW'(STARVE_LIMIT) ? starve : starve + 1'b1;
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      bus.write_enable  <= 1'b0;
      bus.write_address <= '0;
      bus.write_data    <= '0;
      bus.pipe_stall    <= 1'b0;
      pending           <= '0;
      starve            <= '0;
    end else begin
      bus.write_enable  <= pipe_hit || pop || bypass;
      bus.write_address <= pipe_hit ? bus.pipe_write_address : pop ? head.address : bypass ? bus.lu_address : bus.write_address;
      bus.write_data    <= pipe_hit ? bus.pipe_write_data : pop ? head.data : bypass ? bus.lu_data : bus.write_data;
      pending           <= (pending & ~clr_mask) | set_mask;
      starve            <= starve_next;
      bus.pipe_stall    <= starve_next == SW'(STARVE_LIMIT);
    end
endmodule

// File: tb/tb_writeback_arbiter.sv
// tb_writeback_arbiter: table vectors, directed corner sequences and random traffic against a queue model
module tb_writeback_arbiter;
  import wb_pkg::*;
  localparam int DEPTH = 4;
  localparam int LIMIT = 8;
  typedef struct {
    logic        pwe;
    logic [4:0]  pa;
    logic [31:0] pd;
    logic        ewe;
    logic [4:0]  ea;
    logic [31:0] ed;
  } vec_t;
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;
  writeback_arbiter_if #(.DEPTH(DEPTH)) bus ();
  writeback_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (.clock(clock), .reset(reset), .bus(bus));
  int n_vec = 0;
  int n_bad = 0;
  wb_entry_t q[$];
  bit [31:0] busy;
  int undrained;
  logic m_we;
  logic [4:0] m_addr;
  logic [31:0] m_data;
  vec_t tbl [6];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clr();
    bus.pipe_write_enable = 0; bus.pipe_write_address = 0; bus.pipe_write_data = 0;
    bus.lu_issue = 0; bus.lu_issue_address = 0;
    bus.lu_valid = 0; bus.lu_address = 0; bus.lu_data = 0;
  endtask

  task automatic model_reset();
    q.delete(); busy = 0; undrained = 0; m_we = 0; m_addr = 0; m_data = 0;
  endtask

  // called just after a falling edge with inputs driven; returns at the next falling edge
  task automatic step();
    bit pw, byp, popped;
    wb_entry_t e;
    int sz;
    #1;
    sz = q.size();
    chk("lu_ready", 32'(bus.lu_ready), 32'(sz < DEPTH));
    chk("fifo_count", 32'(bus.fifo_count), 32'(sz));
    chk("busy_a", 32'(bus.query_busy_a), 32'(busy[bus.query_address_a] && bus.query_address_a != 0));
    chk("busy_b", 32'(bus.query_busy_b), 32'(busy[bus.query_address_b] && bus.query_address_b != 0));
    pw = bus.pipe_write_enable;
    byp = 0;
`ifdef LU_BYPASS_EN
    byp = sz == 0 && !pw && bus.lu_valid && bus.lu_address != 0;
`endif
    popped = !pw && sz > 0;
    if (pw) begin
      m_we = bus.pipe_write_address != 0;
      if (m_we) begin m_addr = bus.pipe_write_address; m_data = bus.pipe_write_data; end
    end else if (popped) begin
      e = q.pop_front();
      m_we = 1; m_addr = e.address; m_data = e.data; busy[e.address] = 0;
    end else if (byp) begin
      m_we = 1; m_addr = bus.lu_address; m_data = bus.lu_data; busy[bus.lu_address] = 0;
    end else m_we = 0;
    if (bus.lu_issue && bus.lu_issue_address != 0) busy[bus.lu_issue_address] = 1;
    if (bus.lu_valid && sz < DEPTH && bus.lu_address != 0 && !byp) begin
      e.address = bus.lu_address; e.data = bus.lu_data;
      q.push_back(e);
    end
    undrained = (popped || sz == 0) ? 0 : undrained + 1;
    @(posedge clock);
    #1;
    chk("write_enable", 32'(bus.write_enable), 32'(m_we));
    chk("write_address", 32'(bus.write_address), 32'(m_addr));
    chk("write_data", bus.write_data, m_data);
    chk("pipe_stall", 32'(bus.pipe_stall), 32'(undrained >= LIMIT));
    @(negedge clock);
  endtask

  initial begin
    tbl[0] = '{1, 5'd3,  32'h1234,     1, 5'd3,  32'h1234};
    tbl[1] = '{1, 5'd0,  32'h5555,     0, 5'd3,  32'h1234};
    tbl[2] = '{0, 5'd7,  32'h7777,     0, 5'd3,  32'h1234};
    tbl[3] = '{1, 5'd31, 32'hFFFFFFFF, 1, 5'd31, 32'hFFFFFFFF};
    tbl[4] = '{1, 5'd1,  32'h0,        1, 5'd1,  32'h0};
    tbl[5] = '{0, 5'd0,  32'h0,        0, 5'd1,  32'h0};
    clr(); bus.query_address_a = 0; bus.query_address_b = 0;
    model_reset();
    #1;
    chk("reset_we", 32'(bus.write_enable), 0);
    chk("reset_stall", 32'(bus.pipe_stall), 0);
    chk("reset_count", 32'(bus.fifo_count), 0);
    chk("reset_addr", 32'(bus.write_address), 0);
    @(negedge clock); @(negedge clock);
    reset = 0;
    for (int i = 0; i < 6; i++) begin
      clr();
      bus.pipe_write_enable = tbl[i].pwe; bus.pipe_write_address = tbl[i].pa; bus.pipe_write_data = tbl[i].pd;
      step();
      chk("tbl_we", 32'(bus.write_enable), 32'(tbl[i].ewe));
      chk("tbl_addr", 32'(bus.write_address), 32'(tbl[i].ea));
      chk("tbl_data", bus.write_data, tbl[i].ed);
    end
    // issue r9, then its result arrives with the pipe idle
    bus.query_address_a = 9; bus.query_address_b = 0;
    clr(); bus.lu_issue = 1; bus.lu_issue_address = 9; step();
    chk("r9_busy_issued", 32'(bus.query_busy_a), 1);
    clr(); bus.lu_valid = 1; bus.lu_address = 9; bus.lu_data = 32'hDEAD; step();
`ifdef LU_BYPASS_EN
    chk("r9_bypass_we", 32'(bus.write_enable), 1);
    chk("r9_bypass_data", bus.write_data, 32'hDEAD);
    chk("r9_bypass_busy", 32'(bus.query_busy_a), 0);
    clr(); step();
`else
    chk("r9_n1_we", 32'(bus.write_enable), 0);
    chk("r9_n1_busy", 32'(bus.query_busy_a), 1);
    clr(); step();
    chk("r9_n2_we", 32'(bus.write_enable), 1);
    chk("r9_n2_addr", 32'(bus.write_address), 9);
    chk("r9_n2_data", bus.write_data, 32'hDEAD);
    chk("r9_n2_busy", 32'(bus.query_busy_a), 0);
`endif
    // fill under continuous pipe writes until starvation stalls the pipe
    for (int i = 1; i <= 12; i++) begin
      clr();
      bus.pipe_write_enable = 1; bus.pipe_write_address = 5'(i); bus.pipe_write_data = 32'(i);
      if (i <= 4) begin bus.lu_valid = 1; bus.lu_address = 5'(9 + i); bus.lu_data = 32'hA0 + 32'(i); end
      else if (i <= 6) begin bus.lu_valid = 1; bus.lu_address = 5'd20; bus.lu_data = '1; end
      step();
      if (i >= 4) chk("full_lu_ready", 32'(bus.lu_ready), 0);
      if (i == 8) chk("stall_before_limit", 32'(bus.pipe_stall), 0);
      if (i == 9) chk("stall_at_limit", 32'(bus.pipe_stall), 1);
    end
    for (int i = 0; i < 4; i++) begin
      clr(); step();
      chk("drain_addr", 32'(bus.write_address), 32'(10 + i));
      chk("drain_data", bus.write_data, 32'hA1 + 32'(i));
      if (i == 0) chk("stall_drop", 32'(bus.pipe_stall), 0);
    end
    // pop of r4 in the same cycle as a new issue to r4
    bus.query_address_a = 4;
    clr(); bus.lu_issue = 1; bus.lu_issue_address = 4; step();
    clr(); bus.pipe_write_enable = 1; bus.pipe_write_address = 2; bus.lu_valid = 1; bus.lu_address = 4; bus.lu_data = 32'h44; step();
    clr(); bus.lu_issue = 1; bus.lu_issue_address = 4; step();
    chk("r4_popped", 32'(bus.write_address), 4);
    chk("r4_still_busy", 32'(bus.query_busy_a), 1);
    // steady push and pop at count 2 across pointer wrap
    for (int i = 0; i < 12; i++) begin
      clr();
      bus.lu_valid = 1; bus.lu_address = 5'(16 + i % 8); bus.lu_data = 32'h100 + 32'(i);
      bus.pipe_write_enable = i < 2; bus.pipe_write_address = 5'd2;
      step();
      if (i >= 2) begin
        chk("b2b_count", 32'(bus.fifo_count), 2);
        chk("wrap_data", bus.write_data, 32'h100 + 32'(i - 2));
      end
    end
    clr(); step(); step();
    // asynchronous reset with three queued results and r5..r7 pending
    bus.query_address_a = 5; bus.query_address_b = 6;
    for (int i = 0; i < 3; i++) begin
      clr();
      bus.lu_issue = 1; bus.lu_issue_address = 5'(5 + i);
      bus.pipe_write_enable = 1; bus.pipe_write_address = 5'd3; bus.pipe_write_data = 32'(i);
      bus.lu_valid = 1; bus.lu_address = 5'(5 + i); bus.lu_data = 32'(i);
      step();
    end
    chk("pre_reset_count", 32'(bus.fifo_count), 3);
    #2 reset = 1;
    #1;
    chk("async_count", 32'(bus.fifo_count), 0);
    chk("async_busy_a", 32'(bus.query_busy_a), 0);
    chk("async_busy_b", 32'(bus.query_busy_b), 0);
    chk("async_we", 32'(bus.write_enable), 0);
    bus.query_address_a = 7;
    #1 chk("async_busy_r7", 32'(bus.query_busy_a), 0);
    model_reset(); clr();
    @(negedge clock);
    reset = 0;
    // random traffic in phases of differing pipe load
    for (int p = 0; p < 24; p++) begin
      int load;
      load = (p % 3 == 0) ? 10 : (p % 3 == 1) ? 50 : 95;
      for (int c = 0; c < 80; c++) begin
        bus.pipe_write_enable = $urandom_range(99) < load;
        bus.pipe_write_address = 5'($urandom);
        bus.pipe_write_data = $urandom;
        bus.lu_issue = $urandom_range(9) < 3;
        bus.lu_issue_address = 5'($urandom);
        bus.lu_valid = $urandom_range(1) == 1;
        bus.lu_address = 5'($urandom);
        bus.lu_data = $urandom;
        bus.query_address_a = 5'($urandom);
        bus.query_address_b = 5'($urandom);
        step();
      end
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
